// File: rtl/maxnet_if.sv
// Start/done handshake, memory read port and result bus of the Maxnet engine.
// master = host side (drives start and read data), slave = engine side.
interface maxnet_if #(
    parameter int W  = 16,
    parameter int AW = 2,
    parameter int IW = 6
);
    logic          start;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_data;
    logic          busy;
    logic          done;
    logic          valid_winner;
    logic [AW-1:0] winner_idx;
    logic [W-1:0]  winner_val;
    logic [IW-1:0] iter_count;
    logic          timeout;

    modport master (
        output start, mem_data,
        input  mem_rd, mem_addr, busy, done, valid_winner,
               winner_idx, winner_val, iter_count, timeout
    );

    modport slave (
        input  start, mem_data,
        output mem_rd, mem_addr, busy, done, valid_winner,
               winner_idx, winner_val, iter_count, timeout
    );
endinterface

// File: rtl/maxnet_engine.sv
// Maxnet winner-take-all engine: loads N activations from a synchronous memory and
// iterates lateral inhibition until at most one neuron survives or MAX_ITER is reached.
//
// state    | meaning
// IDLE     | wait for start; clears run state when start is accepted
// LOAD     | issue reads 0..N-1, capture word k-1 while reading k
// LAST     | capture the final word
// CHECK    | count nonzero neurons, decide done / timeout / update
// UPDATE   | one parallel inhibition step on all neurons
// DONE     | one-cycle done pulse, results registered
module maxnet_engine #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int FRAC     = 8,
    parameter int EPS      = 51,
    parameter int MAX_ITER = 32,
    parameter int AW       = $clog2(N),
    parameter int IW       = $clog2(MAX_ITER + 1)
) (
    input logic     clk,
    input logic     rst,
    maxnet_if.slave bus
);
    localparam int SW = W + AW;
    localparam int PW = SW + 32;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAST, S_CHECK, S_UPDATE, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [W-1:0]  a_q [N];
    logic [W-1:0]  a_d [N];
    logic          valid_q, valid_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [W-1:0]  val_q, val_d;
    logic          timeout_q, timeout_d;

    logic [SW-1:0] sum;
    logic [SW-1:0] diff;
    logic [PW-1:0] prod;
    logic [PW-1:0] pen;
    logic [CW-1:0] nz;
    logic [AW-1:0] w_idx;
    logic [W-1:0]  w_val;
    logic [W-1:0]  capt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            iter_q    <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            val_q     <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < N; i++) a_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            iter_q    <= iter_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            val_q     <= val_d;
            timeout_q <= timeout_d;
            a_q       <= a_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        iter_d    = iter_q;
        a_d       = a_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        val_d     = val_q;
        timeout_d = timeout_q;
        sum       = '0;
        diff      = '0;
        prod      = '0;
        pen       = '0;
        nz        = '0;
        w_idx     = '0;
        w_val     = '0;

        // All activations are non-negative, so the sum is taken unsigned.
        for (int i = 0; i < N; i++) begin
            sum = sum + SW'(a_q[i]);
            if (a_q[i] != '0) begin
                nz    = nz + CW'(1);
                w_idx = AW'(i);
                w_val = a_q[i];
            end
        end

        capt = bus.mem_data[W-1] ? '0 : bus.mem_data;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    addr_d    = '0;
                    iter_d    = '0;
                    valid_d   = 1'b0;
                    idx_d     = '0;
                    val_d     = '0;
                    timeout_d = 1'b0;
                    for (int i = 0; i < N; i++) a_d[i] = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < N - 1; i++) begin
                    if (addr_q == AW'(i + 1)) a_d[i] = capt;
                end
                if (addr_q == AW'(N - 1)) state_d = S_LAST;
                else                      addr_d  = addr_q + AW'(1);
            end
            S_LAST: begin
                a_d[N-1] = capt;
                state_d  = S_CHECK;
            end
            S_CHECK: begin
                if (nz <= CW'(1)) begin
                    valid_d = (nz == CW'(1));
                    idx_d   = w_idx;
                    val_d   = w_val;
                    state_d = S_DONE;
                end else if (iter_q == IW'(MAX_ITER)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // A penalty larger than the activation means the new value would be negative.
                for (int i = 0; i < N; i++) begin
                    diff = sum - SW'(a_q[i]);
                    prod = PW'(diff) * PW'(EPS);
                    pen  = prod >> FRAC;
                    if (pen > PW'(a_q[i])) a_d[i] = '0;
                    else                   a_d[i] = a_q[i] - pen[W-1:0];
                end
                iter_d  = iter_q + IW'(1);
                state_d = S_CHECK;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_DONE);
    assign bus.mem_rd       = (state_q == S_LOAD);
    assign bus.mem_addr     = (state_q == S_LOAD) ? addr_q : '0;
    assign bus.valid_winner = valid_q;
    assign bus.winner_idx   = idx_q;
    assign bus.winner_val   = val_q;
    assign bus.iter_count   = iter_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_maxnet_engine.sv
// Bench for maxnet_engine: directed cases plus random runs, each checked cycle by cycle
// against an integer Maxnet model of the expected result and done latency.
`timescale 1ns/1ps
module tb_maxnet_engine;
    localparam int N        = 4;
    localparam int W        = 16;
    localparam int FRAC     = 8;
    localparam int EPS      = 51;
    localparam int MAX_ITER = 32;
    localparam int AW       = $clog2(N);
    localparam int IW       = $clog2(MAX_ITER + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    maxnet_if #(.W(W), .AW(AW), .IW(IW)) bus();

    maxnet_engine #(
        .N(N), .W(W), .FRAC(FRAC), .EPS(EPS), .MAX_ITER(MAX_ITER), .AW(AW), .IW(IW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [W-1:0] mem [N];

    always @(posedge clk) begin
        if (rst)             bus.mem_data <= '0;
        else if (bus.mem_rd) bus.mem_data <= mem[bus.mem_addr];
    end

    int vectors     = 0;
    int miscompares = 0;

    int m_valid, m_idx, m_val, m_iter, m_to, dcyc;
    int r_valid, r_idx, r_val, r_iter, r_to, r_done_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_mem(input logic [W-1:0] a0, input logic [W-1:0] a1,
                           input logic [W-1:0] a2, input logic [W-1:0] a3);
        mem[0] = a0; mem[1] = a1; mem[2] = a2; mem[3] = a3;
    endtask

    // Plain-integer Maxnet on the current memory contents.
    task automatic model();
        longint a [N];
        longint s, p, n;
        int     nz, last;
        bit     fin;
        for (int i = 0; i < N; i++) a[i] = mem[i][W-1] ? 0 : longint'(mem[i]);
        m_iter = 0;
        m_to   = 0;
        fin    = 0;
        nz     = 0;
        last   = 0;
        while (!fin) begin
            nz = 0;
            s  = 0;
            for (int i = 0; i < N; i++) begin
                s = s + a[i];
                if (a[i] != 0) begin nz++; last = i; end
            end
            if (nz <= 1) fin = 1;
            else if (m_iter == MAX_ITER) begin fin = 1; m_to = 1; end
            else begin
                for (int i = 0; i < N; i++) begin
                    p    = (EPS * (s - a[i])) / (1 << FRAC);
                    n    = a[i] - p;
                    a[i] = (n < 0) ? 0 : n;
                end
                m_iter++;
            end
        end
        m_valid = (nz == 1) ? 1 : 0;
        m_idx   = (nz == 1) ? last : 0;
        m_val   = (nz == 1) ? int'(a[last]) : 0;
        dcyc    = N + 3 + 2 * m_iter;
    endtask

    // Called at #1 after an edge with the engine idle; the current cycle is cycle 0.
    task automatic run_case(input int poke, input bit hold);
        model();
        r_done_cyc = 0;
        bus.start  = 1'b1;
        for (int c = 1; c <= dcyc; c++) begin
            @(posedge clk); #1;
            if (!hold) bus.start = (c == poke);
            chk("busy", bus.busy, 1);
            chk("mem_rd", bus.mem_rd, (c <= N) ? 1 : 0);
            if (c <= N) chk("mem_addr", bus.mem_addr, c - 1);
            chk("done", bus.done, (c == dcyc) ? 1 : 0);
            if (bus.done && r_done_cyc == 0) r_done_cyc = c;
            if (c == 1) begin
                chk("clr_valid", bus.valid_winner, 0);
                chk("clr_val", bus.winner_val, 0);
                chk("clr_timeout", bus.timeout, 0);
                chk("clr_iter", bus.iter_count, 0);
            end
            if (c == dcyc) begin
                r_valid = bus.valid_winner;
                r_idx   = bus.winner_idx;
                r_val   = bus.winner_val;
                r_iter  = bus.iter_count;
                r_to    = bus.timeout;
                chk("valid_winner", bus.valid_winner, m_valid);
                chk("winner_idx", bus.winner_idx, m_idx);
                chk("winner_val", bus.winner_val, m_val);
                chk("iter_count", bus.iter_count, m_iter);
                chk("timeout", bus.timeout, m_to);
            end
        end
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("hold_val", bus.winner_val, m_val);
        chk("hold_valid", bus.valid_winner, m_valid);
    endtask

    initial begin
        bus.start = 1'b0;
        rst       = 1'b1;
        set_mem(0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_valid", bus.valid_winner, 0);
        chk("rst_iter", bus.iter_count, 0);
        chk("rst_timeout", bus.timeout, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        set_mem(16'h0000, 16'h0000, 16'h0300, 16'h0000);
        run_case(0, 0);
        chk("single_done_cyc", r_done_cyc, 7);
        chk("single_idx", r_idx, 2);
        chk("single_val", r_val, 'h0300);
        chk("single_iter", r_iter, 0);
        chk("single_valid", r_valid, 1);

        set_mem(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        run_case(0, 0);
        chk("two_done_cyc", r_done_cyc, 13);
        chk("two_idx", r_idx, 0);
        chk("two_val", r_val, 'h00D2);
        chk("two_iter", r_iter, 3);

        set_mem(16'h0100, 16'h0100, 16'h0000, 16'h0000);
        run_case(0, 0);
        chk("tie_timeout", r_to, 1);
        chk("tie_iter", r_iter, 32);
        chk("tie_valid", r_valid, 0);
        chk("tie_val", r_val, 0);

        set_mem(0, 0, 0, 0);
        run_case(0, 0);
        chk("zero_done_cyc", r_done_cyc, 7);
        chk("zero_valid", r_valid, 0);
        chk("zero_iter", r_iter, 0);

        set_mem(16'hFF00, 16'h0080, 16'h0000, 16'h0000);
        run_case(0, 0);
        chk("neg_idx", r_idx, 1);
        chk("neg_val", r_val, 'h0080);
        chk("neg_iter", r_iter, 0);

        // Reset in the second UPDATE of the two-neuron case.
        set_mem(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        bus.start = 1'b1;
        for (int c = 1; c <= N + 5; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_iter", bus.iter_count, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_iter", bus.iter_count, 0);
        chk("mid_rst_valid", bus.valid_winner, 0);
        chk("mid_rst_val", bus.winner_val, 0);
        chk("mid_rst_mem_rd", bus.mem_rd, 0);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_busy", bus.busy, 0);
        end
        run_case(0, 0);
        chk("rerun_val", r_val, 'h00D2);

        run_case(5, 0);
        chk("poke_val", r_val, 'h00D2);
        chk("poke_done_cyc", r_done_cyc, 13);

        set_mem(16'h0000, 16'h0000, 16'h0300, 16'h0000);
        run_case(0, 1);
        set_mem(16'h0100, 16'h0080, 16'h0000, 16'h0000);
        run_case(0, 0);
        chk("held_start_val", r_val, 'h00D2);
        chk("held_start_cyc", r_done_cyc, 13);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       mem[i] = '0;
                    1:       mem[i] = W'($urandom_range(1, 'h7FFF));
                    2:       mem[i] = W'($urandom_range(1, 'h0400));
                    default: mem[i] = W'($urandom);
                endcase
            end
            if ($urandom_range(0, 5) == 0) mem[1] = mem[0];
            run_case(($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 12)) : 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/maxnet_engine.md
Name: maxnet_engine

Overview:
- Parametrised Maxnet winner-take-all engine with N neurons. Fetches N activations from a synchronous memory, then iterates a_i <- max(0, a_i - EPS*(S - a_i)) until at most one neuron is nonzero or an iteration limit is hit.
- Reports winner index, winner value, iteration count and a timeout flag over a start/done handshake.
- Successor to the fixed 4-input Maxnet controller: width, depth, epsilon and iteration limit are generic, and it adds an early-exit check, zero-winner detection and a timeout.

Parameters:
- N, 4, number of neurons (>=2)
- W, 16, activation width; signed two's complement, FRAC fractional bits
- FRAC, 8, fractional bits of activations and EPS
- EPS, 51, inhibition weight, unsigned Q(FRAC); 51 ~ 0.2
- MAX_ITER, 32, maximum update iterations before timeout
- AW, $clog2(N), index/address width
- IW, $clog2(MAX_ITER+1), iteration counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin run; sampled only in IDLE
- mem_rd  out  1  memory read strobe
- mem_addr  out  AW  memory read address
- mem_data  in  W  read data, valid the cycle after mem_rd
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of run
- valid_winner  out  1  exactly one neuron nonzero at end
- winner_idx  out  AW  index of winner (0 if none)
- winner_val  out  W  final activation of winner (0 if none)
- iter_count  out  IW  number of UPDATE cycles performed
- timeout  out  1  run ended because MAX_ITER was reached

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named rst. rst forces IDLE from any state, including mid-run, and clears all registers and outputs to 0. No done pulse follows a reset.
- States: IDLE, LOAD, LAST, CHECK, UPDATE, DONE.
  - IDLE: if start, clear addr counter, iter_count, activations and result outputs, then go to LOAD; else stay.
  - LOAD: mem_rd=1, mem_addr=k for k=0..N-1, one per cycle (N cycles). Data for address k-1 is captured into a[k-1] during the same cycle. After k=N-1, go to LAST.
  - LAST: capture a[N-1] (mem_rd=0), then go to CHECK.
  - Capture rule: a captured word with a negative value is stored as 0.
  - CHECK: nz = count of a_i != 0.
    - nz<=1: go to DONE.
    - nz>1 and iter_count==MAX_ITER: set timeout=1, go to DONE.
    - Otherwise go to UPDATE.
  - UPDATE: all neurons update in parallel in one cycle, using a single combinational sum S. iter_count+1. Then go to CHECK.
  - DONE: done=1 for one cycle.
    - If nz==1: valid_winner=1, winner_idx and winner_val taken from that neuron.
    - Otherwise: valid_winner=0, idx=0, val=0.
    - Go to IDLE. Result outputs hold until the next accepted start.
- Arithmetic:
  - S = sum a_i, width W+AW, unsigned (all a_i >= 0).
  - d_i = S - a_i >= 0.
  - p_i = (EPS * d_i) >> FRAC, truncating.
  - n_i = a_i - p_i, signed with enough bits to hold the full difference; if n_i < 0 then a_i <- 0, else a_i <- n_i.
  - No overflow is possible, since n_i <= a_i.
- Latency: start sampled at cycle 0 gives LOAD at cycles 1..N, LAST at N+1, and the first CHECK at N+2. With k updates, done is high at cycle N+3+2k.
- start is ignored while busy. start held high through DONE is accepted on the first IDLE cycle after it.
- Ties: equal nonzero leaders never separate. Such a run ends in timeout with valid_winner=0.
- Zero updates: if a single neuron is already the only nonzero after load, iter_count=0.

Test Plan (N=4, W=16, FRAC=8, EPS=51, MAX_ITER=32; done cycle counted from start at cycle 0):
- Load [0x0000,0x0000,0x0300,0x0000] -> done at cycle 7, valid_winner=1, idx=2, val=0x0300, iter_count=0, timeout=0. Check mem_addr 0..3 on cycles 1..4.
- Load [0x0100,0x0080,0,0] -> after update 1: a=[0x00E7,0x004D]; after update 2: [0x00D8,0x001F]; after update 3: [0x00D2,0]. Done at cycle 13: idx=0, val=0x00D2, iter_count=3, valid_winner=1.
- Load [0x0100,0x0100,0,0] -> done with timeout=1, iter_count=32, valid_winner=0, idx=0, val=0.
- Load all zero -> done at cycle 7, valid_winner=0, iter_count=0. Load [0xFF00,0x0080,0,0] -> negative clamped; idx=1, val=0x0080, iter_count=0.
- rst asserted during UPDATE of the 2-neuron case -> next cycle IDLE, all outputs 0, no done pulse. A subsequent start reruns and yields val=0x00D2.
- start pulsed while busy -> ignored, result unchanged. start held high through DONE -> new run begins on the following IDLE cycle.
